engine_sched: RTL

Task scheduler sitting between the command/status block and `engine`. It accepts one layer command, then walks the output feature map one engine task at a time: pixel row, pixel column, and 16-channel output group. For each task it computes the DMA start addresses, raises `engine_ready`, waits for `engine_valid`, then pulses the engine reset so the engine can accept the next task. It also provides a watchdog and layer-done and error reporting.

---
 rtl/engine_sched_if.sv | 32 +++
 rtl/engine_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/engine_sched_if.sv
// engine_sched_if: layer command bus between the command block and engine_sched.
// The command block drives it as master; the scheduler consumes it as slave.
interface engine_sched_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op_type;
    logic [7:0]  cmd_o_side;
    logic [7:0]  cmd_i_side;
    logic [3:0]  cmd_stride;
    logic [7:0]  cmd_ch_groups;
    logic [31:0] cmd_op_num;
    logic [29:0] cmd_data_addr;
    logic [29:0] cmd_weight_addr;
    logic [29:0] cmd_result_addr;
    logic [29:0] cmd_weight_step;

    modport master (
        output cmd_valid, cmd_op_type, cmd_o_side, cmd_i_side,
        output cmd_stride, cmd_ch_groups, cmd_op_num,
        output cmd_data_addr, cmd_weight_addr, cmd_result_addr,
        output cmd_weight_step,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op_type, cmd_o_side, cmd_i_side,
        input  cmd_stride, cmd_ch_groups, cmd_op_num,
        input  cmd_data_addr, cmd_weight_addr, cmd_result_addr,
        input  cmd_weight_step,
        output cmd_ready
    );
endinterface

// File: rtl/engine_sched.sv
// engine_sched: walks one layer as y/x/channel-group engine tasks,
// producing DMA start addresses, engine handshake, watchdog and done/err.
module engine_sched #(
    parameter int BURST_LEN  = 16,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1048575
) (
    input  logic          clk,
    input  logic          rst_n,
    engine_sched_if.slave cmd,
    output logic          engine_ready,
    input  logic          engine_valid,
    output logic          eng_rst,
    output logic [2:0]    op_type,
    output logic [31:0]   op_num,
    output logic [29:0]   data_start_addr,
    output logic [29:0]   weight_start_addr,
    output logic [29:0]   result_start_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [19:0] WD_LAST  = 20'(TIMEOUT - 1);
    localparam logic [3:0]  RC_LAST  = 4'(RST_CYCLES - 1);
    localparam logic [29:0] RES_STEP = 30'(BURST_LEN);

    state_t      state, state_d;
    logic [7:0]  o_side, i_side, ch_groups;
    logic [3:0]  stride;
    logic [29:0] data_base, weight_base, result_base, weight_step;
    logic [29:0] row_step, col_step, row_ptr;
    logic [11:0] row_prod;
    logic [7:0]  x, y, g;
    logic [19:0] wd;
    logic [3:0]  rcnt;
    logic        rdy_d, erst_d, done_d, err_d;
    logic        accept, adv, last, pool;

    assign cmd.cmd_ready = (state == S_IDLE) && rst_n;
    assign pool = (op_type == 3'd4) || (op_type == 3'd5);
    assign row_prod = {8'd0, stride} * {4'd0, i_side};
    assign last = (x == o_side - 8'd1) && (y == o_side - 8'd1)
               && (g == ch_groups - 8'd1);

    always_comb begin
        state_d = state;
        rdy_d   = 1'b0;
        erst_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err;
        accept  = 1'b0;
        adv     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    accept  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (o_side == 8'd0 || ch_groups == 8'd0)
                    state_d = S_DONE;
                else
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                rdy_d   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // a completion in the expiry cycle still counts as success
                if (engine_valid) begin
                    erst_d  = 1'b1;
                    state_d = S_RELEASE;
                end else if (wd == WD_LAST) begin
                    erst_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    rdy_d = 1'b1;
                end
            end
            S_RELEASE: begin
                if (rcnt == RC_LAST) begin
                    adv     = 1'b1;
                    state_d = last ? S_DONE : S_ISSUE;
                end else begin
                    erst_d = 1'b1;
                end
            end
            S_DONE: begin
                // first cycle raises done, second returns to IDLE
                if (done)
                    state_d = S_IDLE;
                else
                    done_d = 1'b1;
            end
            S_ERROR: begin
                if (rcnt == RC_LAST)
                    state_d = S_IDLE;
                else
                    erst_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            engine_ready <= 1'b0;
            eng_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            engine_ready <= rdy_d;
            eng_rst      <= erst_d;
            done         <= done_d;
            err          <= err_d;
            busy         <= (state_d != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_side            <= '0;
            i_side            <= '0;
            ch_groups         <= '0;
            stride            <= '0;
            data_base         <= '0;
            weight_base       <= '0;
            result_base       <= '0;
            weight_step       <= '0;
            op_type           <= '0;
            op_num            <= '0;
            row_step          <= '0;
            col_step          <= '0;
            row_ptr           <= '0;
            data_start_addr   <= '0;
            weight_start_addr <= '0;
            result_start_addr <= '0;
            x                 <= '0;
            y                 <= '0;
            g                 <= '0;
            wd                <= '0;
            rcnt              <= '0;
        end else begin
            if (accept) begin
                o_side      <= cmd.cmd_o_side;
                i_side      <= cmd.cmd_i_side;
                ch_groups   <= cmd.cmd_ch_groups;
                stride      <= cmd.cmd_stride;
                data_base   <= cmd.cmd_data_addr;
                weight_base <= cmd.cmd_weight_addr;
                result_base <= cmd.cmd_result_addr;
                weight_step <= cmd.cmd_weight_step;
                op_type     <= cmd.cmd_op_type;
                op_num      <= cmd.cmd_op_num;
            end
            wd   <= (state == S_WAIT) ? wd + 20'd1 : 20'd0;
            rcnt <= (state == S_RELEASE || state == S_ERROR)
                  ? rcnt + 4'd1 : 4'd0;
            if (state == S_SETUP) begin
                row_step          <= {14'd0, row_prod, 4'd0};
                col_step          <= {22'd0, stride, 4'd0};
                row_ptr           <= data_base;
                data_start_addr   <= data_base;
                weight_start_addr <= weight_base;
                result_start_addr <= result_base;
                x                 <= '0;
                y                 <= '0;
                g                 <= '0;
            end
            if (adv) begin
                result_start_addr <= result_start_addr + RES_STEP;
                if (g != ch_groups - 8'd1) begin
                    g <= g + 8'd1;
                    if (!pool)
                        weight_start_addr <= weight_start_addr + weight_step;
                end else begin
                    g                 <= '0;
                    weight_start_addr <= weight_base;
                    if (x != o_side - 8'd1) begin
                        x               <= x + 8'd1;
                        data_start_addr <= data_start_addr + col_step;
                    end else begin
                        x               <= '0;
                        y               <= y + 8'd1;
                        row_ptr         <= row_ptr + row_step;
                        data_start_addr <= row_ptr + row_step;
                    end
                end
            end
        end
    end

endmodule
